// File: rtl/nios_timer_mc.sv
// Multi-channel Avalon-MM interval timer: per-channel prescaled down-counter with
// period reload, compare flag, PWM output and snapshot capture.
module nios_timer_mc #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned PRESC_W      = 8,
    parameter int unsigned RESET_PERIOD = 4999
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         chipselect,
    input  logic                         write_n,
    input  logic [$clog2(NUM_CH)+2:0]    address,
    input  logic [31:0]                  writedata,
    output logic [31:0]                  readdata,
    output logic                         irq,
    output logic [NUM_CH-1:0]            irq_vec,
    output logic [NUM_CH-1:0]            pwm_out
);

    localparam logic [CNT_W-1:0] RST_CNT = CNT_W'(RESET_PERIOD);

    localparam logic [2:0] REG_STATUS  = 3'd0;
    localparam logic [2:0] REG_CONTROL = 3'd1;
    localparam logic [2:0] REG_PERIOD  = 3'd2;
    localparam logic [2:0] REG_COMPARE = 3'd3;
    localparam logic [2:0] REG_SNAP    = 3'd4;
    localparam logic [2:0] REG_PRESC   = 3'd5;

    logic [CNT_W-1:0]   count_q   [NUM_CH];
    logic [CNT_W-1:0]   count_d   [NUM_CH];
    logic [CNT_W-1:0]   period_q  [NUM_CH];
    logic [CNT_W-1:0]   period_d  [NUM_CH];
    logic [CNT_W-1:0]   compare_q [NUM_CH];
    logic [CNT_W-1:0]   compare_d [NUM_CH];
    logic [CNT_W-1:0]   snap_q    [NUM_CH];
    logic [CNT_W-1:0]   snap_d    [NUM_CH];
    logic [PRESC_W-1:0] presc_q   [NUM_CH];
    logic [PRESC_W-1:0] presc_d   [NUM_CH];
    logic [PRESC_W-1:0] pcnt_q    [NUM_CH];
    logic [PRESC_W-1:0] pcnt_d    [NUM_CH];

    logic [NUM_CH-1:0] run_q, run_d;
    logic [NUM_CH-1:0] to_q, to_d;
    logic [NUM_CH-1:0] cf_q, cf_d;
    logic [NUM_CH-1:0] ito_q, ito_d;
    logic [NUM_CH-1:0] cont_q, cont_d;
    logic [NUM_CH-1:0] icf_q, icf_d;
    logic [NUM_CH-1:0] pwm_en_q, pwm_en_d;
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic [31:0]       readdata_q, readdata_d;

    logic              wr_en;
    logic [3:0]        ch_sel;
    logic              ch_ok;
    logic [2:0]        reg_sel;
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] tick;

    // Bus decode and per-channel prescaler tick
    always_comb begin
        wr_en   = chipselect & ~write_n;
        ch_sel  = 4'(address >> 3);
        reg_sel = address[2:0];
        ch_ok   = ch_sel < 4'(NUM_CH);
        for (int i = 0; i < NUM_CH; i++) begin
            ch_wr[i] = wr_en & ch_ok & (ch_sel == 4'(i));
            tick[i]  = run_q[i] & (pcnt_q[i] == '0);
        end
    end

    // Next state: flag clears first, then tick events, then run/period overrides
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            count_d[i]   = count_q[i];
            period_d[i]  = period_q[i];
            compare_d[i] = compare_q[i];
            snap_d[i]    = snap_q[i];
            presc_d[i]   = presc_q[i];
            pcnt_d[i]    = pcnt_q[i];
            run_d[i]     = run_q[i];
            to_d[i]      = to_q[i];
            cf_d[i]      = cf_q[i];
            ito_d[i]     = ito_q[i];
            cont_d[i]    = cont_q[i];
            icf_d[i]     = icf_q[i];
            pwm_en_d[i]  = pwm_en_q[i];
            pwm_d[i]     = run_q[i] & pwm_en_q[i] & (count_q[i] < compare_q[i]);

            if (ch_wr[i]) begin
                case (reg_sel)
                    REG_STATUS: begin
                        if (writedata[0]) to_d[i] = 1'b0;
                        if (writedata[2]) cf_d[i] = 1'b0;
                    end
                    REG_CONTROL: begin
                        ito_d[i]    = writedata[0];
                        cont_d[i]   = writedata[1];
                        icf_d[i]    = writedata[4];
                        pwm_en_d[i] = writedata[5];
                    end
                    REG_COMPARE: compare_d[i] = writedata[CNT_W-1:0];
                    REG_SNAP:    snap_d[i]    = count_q[i];
                    REG_PRESC:   presc_d[i]   = writedata[PRESC_W-1:0];
                    default: ;
                endcase
            end

            if (tick[i]) begin
                pcnt_d[i] = presc_q[i];
                if (count_q[i] == '0) begin
                    count_d[i] = period_q[i];
                    to_d[i]    = 1'b1;
                    if (!cont_q[i]) run_d[i] = 1'b0;
                end else begin
                    count_d[i] = count_q[i] - CNT_W'(1);
                end
                if (count_q[i] == compare_q[i]) cf_d[i] = 1'b1;
            end else if (run_q[i]) begin
                pcnt_d[i] = pcnt_q[i] - PRESC_W'(1);
            end

            if (ch_wr[i] && reg_sel == REG_CONTROL) begin
                if (writedata[3]) run_d[i] = 1'b0;
                if (writedata[2]) begin
                    run_d[i]  = 1'b1;
                    pcnt_d[i] = presc_q[i];
                end
            end

            // Legacy force-reload: a period write stops the channel and reloads the count
            if (ch_wr[i] && reg_sel == REG_PERIOD) begin
                period_d[i] = writedata[CNT_W-1:0];
                count_d[i]  = writedata[CNT_W-1:0];
                run_d[i]    = 1'b0;
                pcnt_d[i]   = presc_q[i];
            end
        end
    end

    // Read mux, registered every cycle
    always_comb begin
        readdata_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_ok && ch_sel == 4'(i)) begin
                case (reg_sel)
                    REG_STATUS:  readdata_d = 32'({cf_q[i], run_q[i], to_q[i]});
                    REG_CONTROL: readdata_d = 32'({pwm_en_q[i], icf_q[i], 2'b00, cont_q[i], ito_q[i]});
                    REG_PERIOD:  readdata_d = 32'(period_q[i]);
                    REG_COMPARE: readdata_d = 32'(compare_q[i]);
                    REG_SNAP:    readdata_d = 32'(snap_q[i]);
                    REG_PRESC:   readdata_d = 32'(presc_q[i]);
                    default:     readdata_d = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]   <= RST_CNT;
                period_q[i]  <= RST_CNT;
                compare_q[i] <= '0;
                snap_q[i]    <= '0;
                presc_q[i]   <= '0;
                pcnt_q[i]    <= '0;
            end
            run_q      <= '0;
            to_q       <= '0;
            cf_q       <= '0;
            ito_q      <= '0;
            cont_q     <= '0;
            icf_q      <= '0;
            pwm_en_q   <= '0;
            pwm_q      <= '0;
            readdata_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                count_q[i]   <= count_d[i];
                period_q[i]  <= period_d[i];
                compare_q[i] <= compare_d[i];
                snap_q[i]    <= snap_d[i];
                presc_q[i]   <= presc_d[i];
                pcnt_q[i]    <= pcnt_d[i];
            end
            run_q      <= run_d;
            to_q       <= to_d;
            cf_q       <= cf_d;
            ito_q      <= ito_d;
            cont_q     <= cont_d;
            icf_q      <= icf_d;
            pwm_en_q   <= pwm_en_d;
            pwm_q      <= pwm_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign pwm_out  = pwm_q;
    assign irq_vec  = (to_q & ito_q) | (cf_q & icf_q);
    assign irq      = |irq_vec;

endmodule

// File: doc/nios_timer_mc.md
# nios_timer_mc

Multi-channel, parametrised successor to the system's single-channel Avalon interval timer. Provides `NUM_CH` independent down-counting timers, each with configurable counter width, clock prescaler, one-shot/continuous modes, a compare register with interrupt and PWM output, and snapshot capture. Sits on the Nios II data master as one Avalon-MM slave, with one combined `irq` line to the CPU and per-channel `pwm_out` pins to the audio/output logic.

## Interface
- `NUM_CH`, 4: channel count, 1..8.
- `CNT_W`, 32: counter/period/compare width, 8..32.
- `PRESC_W`, 8: prescaler register width, 1..16.
- `RESET_PERIOD`, 4999: reset value of every PERIOD and counter; truncated to `CNT_W`.
- `clk` in 1: system clock; all logic on rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `chipselect` in 1: Avalon slave select.
- `write_n` in 1: active-low write strobe.
- `address` in `clog2(NUM_CH)+3`: {channel, register}; register = address[2:0]. For `NUM_CH`=1 the channel field is 0 bits wide.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `irq` out 1: OR of all channel interrupts.
- `irq_vec` out `NUM_CH`: per-channel interrupt.
- `pwm_out` out `NUM_CH`: per-channel registered PWM.

## Operation
- Write = `chipselect & ~write_n`. Registers per channel:
  - 0 STATUS: [0] TO, [1] RUN (read-only), [2] CF. Writing 1 to bit 0 or bit 2 clears that flag.
  - 1 CONTROL: [0] ITO, [1] CONT, [2] START strobe, [3] STOP strobe, [4] ICF, [5] PWM_EN. Bits 2 and 3 are not stored and read 0.
  - 2 PERIOD, 3 COMPARE: `CNT_W` bits.
  - 4 SNAP: a write captures the counter into the snapshot; a read returns the snapshot.
  - 5 PRESCALE: `PRESC_W` bits; divisor = value+1.
  - 6, 7: read 0; writes ignored.
- Unused upper read bits are 0. Reads of a channel index ≥ `NUM_CH` return 0; writes to it are ignored.
- Prescaler: `pcnt` counts down while RUN. Tick = RUN & (`pcnt`==0). On a tick `pcnt` reloads from PRESCALE. START and PERIOD writes also load `pcnt` from PRESCALE.
- On each tick:
  - If count==0: count ← PERIOD and TO is set. If CONT=0, RUN is cleared.
  - Otherwise: count ← count−1.
  - If count==COMPARE (pre-update value): CF is set.
- START sets RUN. STOP clears RUN. If START and STOP are written together, START wins.
- PERIOD write: on the next edge, count ← new PERIOD and RUN ← 0, matching the legacy force-reload behaviour.
- `irq_vec[i]` = (TO & ITO) | (CF & ICF), taken from registered flags. `irq` = OR of `irq_vec`.
- `pwm_out[i]` is registered: next = RUN & PWM_EN & (count < COMPARE).
  - Duty = COMPARE/(PERIOD+1).
  - COMPARE=0 gives constant 0; COMPARE>PERIOD gives constant 1 while running.
- Channel interaction: none; channels share only the bus decode and the readdata mux.

## Timing
- Reset values (applied on the first edge with `reset_n`=0):
  - `readdata`=0, `irq`=0, `irq_vec`=0, `pwm_out`=0.
  - RUN, TO, CF, CONTROL = 0.
  - PERIOD = count = `RESET_PERIOD`.
  - COMPARE = SNAP = PRESCALE = `pcnt` = 0.
- Read latency 1: `readdata` reflects the address sampled at edge t and is valid after edge t, i.e. one wait-state-free cycle. `readdata` updates every cycle regardless of `chipselect`.
- Writes take effect at the edge on which they are sampled.
- START at edge t: first tick at edge t+1 when PRESCALE=0.
- TO period = (PERIOD+1)·(PRESCALE+1) cycles.
- TO rises at the edge where the tick sees count==0. `irq` is high in the following cycle.
- Flag clear and flag event on the same edge: event wins, so the flag stays set and no interrupt is lost.
- SNAP write and tick on the same edge: the captured value is the pre-update count.
- STOP on a tick edge: the tick's count update and flag events still occur, then RUN=0.
- Reset mid-count: all state returns to reset values on that edge regardless of bus activity.
- Counter arithmetic: unsigned, `CNT_W` bits; wrap is impossible because 0 reloads.

## Test plan
- Reset, then read every register of channel 0 → STATUS=0, PERIOD=4999, COMPARE=0, PRESCALE=0, SNAP=0; `irq`=0.
- Ch1: PERIOD=9, CONTROL=0x3 (ITO, CONT), CONTROL=0x7 (START) → TO every 10 cycles; `irq` and `irq_vec[1]` high one cycle after the first TO; writing STATUS=0x1 clears it; RUN stays 1.
- Ch0: one-shot, PERIOD=3, PRESCALE=2, START → TO after exactly 12 cycles; RUN=0 afterwards; count=3.
- Ch2: PERIOD=7, COMPARE=3, PWM_EN | CONT, START → `pwm_out[2]` high 3 of every 8 cycles; CF set each period. Also cover COMPARE=0 (always low) and COMPARE=9 (always high).
- Ch3 running with PERIOD=100: SNAP write → SNAP reads the pre-tick count. PERIOD write mid-run → RUN=0 and count=new PERIOD next cycle.
- Edge cases:
  - START and STOP in the same write → RUN=1.
  - STATUS clear on the same edge as TO → TO remains 1.
  - `reset_n` low mid-run on ch1 → reset values on that edge.
